// File: rtl/axi_rd_arbiter.sv
// Two-master to one-slave AXI4 read arbiter (AR/R channels only).
// One read is outstanding at a time; the grant is held until the rlast beat completes.
module axi_rd_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [48:0] m0_ar_i,
  input  logic        m0_arvalid_i,
  output logic        m0_arready_o,
  output logic [70:0] m0_r_o,
  output logic        m0_rvalid_o,
  input  logic        m0_rready_i,
  input  logic [48:0] m1_ar_i,
  input  logic        m1_arvalid_i,
  output logic        m1_arready_o,
  output logic [70:0] m1_r_o,
  output logic        m1_rvalid_o,
  input  logic        m1_rready_i,
  output logic [48:0] s_ar_o,
  output logic        s_arvalid_o,
  input  logic        s_arready_i,
  input  logic [70:0] s_r_i,
  input  logic        s_rvalid_i,
  output logic        s_rready_o
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_e;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_grant_q, last_grant_d;
  logic [48:0] s_ar_q, s_ar_d;
  logic        win;

  // On contention round-robin favours the master not served last; fixed mode favours the LSU
  always_comb begin
    win = m1_arvalid_i;
    if (m0_arvalid_i && m1_arvalid_i) begin
      win = RR_EN ? ~last_grant_q : 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      s_ar_q       <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      s_ar_q       <= s_ar_d;
    end
  end

  assign s_ar_o = s_ar_q;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    s_ar_d       = s_ar_q;
    m0_arready_o = 1'b0;
    m1_arready_o = 1'b0;
    m0_r_o       = '0;
    m1_r_o       = '0;
    m0_rvalid_o  = 1'b0;
    m1_rvalid_o  = 1'b0;
    s_arvalid_o  = 1'b0;
    s_rready_o   = 1'b0;

    case (state_q)
      IDLE: begin
        if (m0_arvalid_i || m1_arvalid_i) begin
          m0_arready_o = ~win;
          m1_arready_o = win;
          owner_d      = win;
          s_ar_d       = win ? m1_ar_i : m0_ar_i;
          state_d      = ADDR;
        end
      end
      ADDR: begin
        s_arvalid_o = 1'b1;
        if (s_arready_i) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (owner_q) begin
          m1_r_o      = s_r_i;
          m1_rvalid_o = s_rvalid_i;
          s_rready_o  = m1_rready_i;
        end else begin
          m0_r_o      = s_r_i;
          m0_rvalid_o = s_rvalid_i;
          s_rready_o  = m0_rready_i;
        end
        // Only the rlast beat ends the burst; beat counting against arlen is not needed
        if (s_rvalid_i && s_rready_o && s_r_i[64]) begin
          state_d      = IDLE;
          last_grant_d = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase

    // Keep every handshake closed while reset is held so no beat or grant leaks out
    if (reset) begin
      m0_arready_o = 1'b0;
      m1_arready_o = 1'b0;
      m0_r_o       = '0;
      m1_r_o       = '0;
      m0_rvalid_o  = 1'b0;
      m1_rvalid_o  = 1'b0;
      s_arvalid_o  = 1'b0;
      s_rready_o   = 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: directed scenarios plus randomized traffic, all checked each
// cycle against a transaction-level model of who should own the slave port.
module tb_axi_rd_arbiter;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [48:0] mAr[2];
  logic        mArvalid[2];
  logic        mRready[2];
  logic        m0Arready, m1Arready, m0Rvalid, m1Rvalid;
  logic [70:0] m0R, m1R;
  logic [48:0] sAr;
  logic        sArvalid, sArready, sRvalid, sRready;
  logic [70:0] sR;

  logic        fpM0Arready, fpM1Arready, fpM0Rvalid, fpM1Rvalid, fpSArvalid, fpSRready;
  logic [70:0] fpM0R, fpM1R;
  logic [48:0] fpSAr;

  axi_rd_arbiter #(.RR_EN(1'b1)) dut (
    .clock(clock), .reset(reset),
    .m0_ar_i(mAr[0]), .m0_arvalid_i(mArvalid[0]), .m0_arready_o(m0Arready),
    .m0_r_o(m0R), .m0_rvalid_o(m0Rvalid), .m0_rready_i(mRready[0]),
    .m1_ar_i(mAr[1]), .m1_arvalid_i(mArvalid[1]), .m1_arready_o(m1Arready),
    .m1_r_o(m1R), .m1_rvalid_o(m1Rvalid), .m1_rready_i(mRready[1]),
    .s_ar_o(sAr), .s_arvalid_o(sArvalid), .s_arready_i(sArready),
    .s_r_i(sR), .s_rvalid_i(sRvalid), .s_rready_o(sRready)
  );

  // Fixed-priority instance shares the stimulus; only its first contended grant is checked
  axi_rd_arbiter #(.RR_EN(1'b0)) dutFixed (
    .clock(clock), .reset(reset),
    .m0_ar_i(mAr[0]), .m0_arvalid_i(mArvalid[0]), .m0_arready_o(fpM0Arready),
    .m0_r_o(fpM0R), .m0_rvalid_o(fpM0Rvalid), .m0_rready_i(mRready[0]),
    .m1_ar_i(mAr[1]), .m1_arvalid_i(mArvalid[1]), .m1_arready_o(fpM1Arready),
    .m1_r_o(fpM1R), .m1_rvalid_o(fpM1Rvalid), .m1_rready_i(mRready[1]),
    .s_ar_o(fpSAr), .s_arvalid_o(fpSArvalid), .s_arready_i(sArready),
    .s_r_i(sR), .s_rvalid_i(sRvalid), .s_rready_o(fpSRready)
  );

  int assertCount = 0;
  int failCount   = 0;

  // Stimulus agent state
  logic [48:0] reqQ0[$], reqQ1[$];
  logic [63:0] dataQ[$];
  bit          mDone[2];
  bit          randMode = 0;
  int          rreadyMode = 0;
  int          arreadyStall = 0;
  int          sPending = 0;
  bit          sBeatLive = 0;
  bit          sRHs = 0;
  logic [1:0]  lastResp = 2'b00;

  // Reference model: is a read outstanding, to whom, and has its address gone out yet
  bit          busy = 0;
  bit          addrDone = 0;
  int          own = 0;
  int          lastWin = 1;
  logic [48:0] expAr = '0;

  // Observation log
  int          grantLog[$];
  logic [63:0] rx1[$];
  int          rlastCount = 0;
  int          m1Beats = 0;
  bit          m0RvSeen = 0;
  bit          m0ArdySeen = 0;
  logic [1:0]  m1LastResp = 2'b00;

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [48:0] mkAr(input logic [7:0] len, input logic [31:0] addr);
    return {4'($urandom), len, 3'd3, 2'b01, addr};
  endfunction

  task automatic applyStimulus();
    logic [63:0] data;
    bit          last;
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        mArvalid[i] = 1'b0;
        mDone[i]    = 1'b0;
      end
      sArready  = 1'b0;
      sRvalid   = 1'b0;
      sBeatLive = 1'b0;
      sRHs      = 1'b0;
      sPending  = 0;
      return;
    end
    for (int i = 0; i < 2; i++) begin
      if (mDone[i]) begin
        mArvalid[i] = 1'b0;
        mDone[i]    = 1'b0;
      end
      if (!mArvalid[i] && (!randMode || $urandom_range(0, 2) == 0)) begin
        if (i == 0 && reqQ0.size() > 0) begin
          mAr[0] = reqQ0.pop_front();
          mArvalid[0] = 1'b1;
        end else if (i == 1 && reqQ1.size() > 0) begin
          mAr[1] = reqQ1.pop_front();
          mArvalid[1] = 1'b1;
        end
      end
      case (rreadyMode)
        1:       mRready[i] = 1'($urandom);
        2:       mRready[i] = ~mRready[i];
        default: mRready[i] = 1'b1;
      endcase
    end
    if (arreadyStall > 0) begin
      sArready = 1'b0;
      arreadyStall--;
    end else begin
      sArready = randMode ? 1'($urandom) : 1'b1;
    end
    if (sRHs || !sBeatLive) begin
      sRvalid   = 1'b0;
      sBeatLive = 1'b0;
    end
    sRHs = 1'b0;
    if (!sBeatLive && sPending > 0 && (!randMode || $urandom_range(0, 3) != 0)) begin
      data = (dataQ.size() > 0) ? dataQ.pop_front() : {$urandom, $urandom};
      last = (sPending == 1);
      sR = {4'($urandom), randMode ? 2'($urandom) : (last ? lastResp : 2'b00), last, data};
      sRvalid   = 1'b1;
      sBeatLive = 1'b1;
    end else if (!sBeatLive && sPending == 0 && randMode && $urandom_range(0, 7) == 0) begin
      sR      = 71'({$urandom, $urandom, $urandom});
      sRvalid = 1'b1;
    end
  endtask

  task automatic modelCheck();
    logic        ardy[2];
    logic        rv[2];
    logic [70:0] rr[2];
    int          win;
    bit          dp;
    ardy[0] = m0Arready; ardy[1] = m1Arready;
    rv[0]   = m0Rvalid;  rv[1]   = m1Rvalid;
    rr[0]   = m0R;       rr[1]   = m1R;
    win = -1;
    if (!reset && !busy) begin
      if (mArvalid[0] && mArvalid[1]) win = 1 - lastWin;
      else if (mArvalid[0])           win = 0;
      else if (mArvalid[1])           win = 1;
    end
    dp = !reset && busy && addrDone;
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("m%0d_arready", i), ardy[i], win == i);
      checkOutput($sformatf("m%0d_rvalid", i), rv[i], dp && own == i && sRvalid);
      checkOutput($sformatf("m%0d_r", i), rr[i], (dp && own == i) ? sR : 71'd0);
    end
    checkOutput("s_arvalid", sArvalid, !reset && busy && !addrDone);
    if (!reset && busy && !addrDone) checkOutput("s_ar", sAr, expAr);
    checkOutput("s_rready", sRready, dp ? mRready[own] : 1'b0);

    // Agents react to what the DUT actually did this cycle
    for (int i = 0; i < 2; i++) begin
      if (mArvalid[i] && ardy[i]) begin
        mDone[i] = 1'b1;
        grantLog.push_back(i);
      end
    end
    if (sArvalid && sArready) sPending = int'(sAr[44:37]) + 1;
    if (sRvalid && sRready && sBeatLive) begin
      sRHs = 1'b1;
      if (sPending > 0) sPending--;
      if (sR[64]) rlastCount++;
    end
    if (m1Rvalid && mRready[1]) begin
      m1Beats++;
      rx1.push_back(m1R[63:0]);
      if (m1R[64]) m1LastResp = m1R[66:65];
    end
    if (rv[0]) m0RvSeen = 1'b1;
    if (ardy[0]) m0ArdySeen = 1'b1;

    if (reset) begin
      busy = 0; addrDone = 0; lastWin = 1;
    end else if (win >= 0) begin
      busy = 1; own = win; addrDone = 0; expAr = mAr[win];
    end else if (busy && !addrDone && sArready) begin
      addrDone = 1;
    end else if (dp && sRvalid && mRready[own] && sR[64]) begin
      busy = 0; lastWin = own;
    end
  endtask

  task automatic tick(input bit rst);
    @(negedge clock);
    reset = rst;
    applyStimulus();
    #1;
    modelCheck();
  endtask

  task automatic runUntilIdle(input int maxCycles, input string tag);
    int n = 0;
    while ((busy || reqQ0.size() > 0 || reqQ1.size() > 0 || mArvalid[0] || mArvalid[1]) && n < maxCycles) begin
      tick(0);
      n++;
    end
    checkOutput(tag, n < maxCycles, 1'b1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [48:0] a;
    int          rc0;
    int          n;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      mAr[i] = '0; mArvalid[i] = 1'b0; mRready[i] = 1'b0; mDone[i] = 1'b0;
    end
    sArready = 1'b0; sRvalid = 1'b0; sR = '0;

    tick(1);
    tick(1);
    tick(0);
    checkOutput("rst_s_ar", sAr, 49'd0);
    checkOutput("rst_outputs", {sArvalid, sRready, m0Rvalid, m1Rvalid, m0Arready, m1Arready}, 6'd0);

    // Single M0 read, one beat
    a = {4'h1, 8'd0, 3'd3, 2'b01, 32'h8000_0000};
    reqQ0.push_back(a);
    dataQ.push_back(64'h1122_3344_5566_7788);
    tick(0);
    checkOutput("t1_m0_arready", m0Arready, 1'b1);
    tick(0);
    checkOutput("t1_s_arvalid", sArvalid, 1'b1);
    checkOutput("t1_s_ar", sAr, a);
    tick(0);
    checkOutput("t1_m0_rvalid", m0Rvalid, 1'b1);
    checkOutput("t1_m0_rdata", m0R[63:0], 64'h1122_3344_5566_7788);
    checkOutput("t1_m1_rvalid", m1Rvalid, 1'b0);
    tick(0);
    checkOutput("t1_back_idle", {sArvalid, sRready, m0Rvalid}, 3'd0);

    // Simultaneous requests after reset: alternation under round-robin
    tick(1);
    for (int k = 0; k < 3; k++) begin
      reqQ0.push_back(mkAr(8'd0, 32'h1000 + 32'(k)));
      reqQ1.push_back(mkAr(8'd0, 32'h2000 + 32'(k)));
    end
    grantLog.delete();
    tick(0);
    checkOutput("t2_rr_m0_first", m0Arready, 1'b1);
    checkOutput("t2_rr_m1_wait", m1Arready, 1'b0);
    checkOutput("t2_fixed_m1_first", fpM1Arready, 1'b1);
    checkOutput("t2_fixed_m0_wait", fpM0Arready, 1'b0);
    runUntilIdle(100, "t2_drain");
    checkOutput("t2_grant_count", grantLog.size(), 6);
    for (int k = 0; k < grantLog.size() && k < 6; k++)
      checkOutput($sformatf("t2_grant_%0d", k), grantLog[k], k % 2);

    // M1 four-beat burst with toggling rready while M0 waits
    rx1.delete();
    m1Beats = 0;
    for (int k = 0; k < 4; k++) dataQ.push_back(64'hA5A5_0000_0000_0000 + 64'(k));
    reqQ1.push_back(mkAr(8'd3, 32'h3000));
    rreadyMode = 2;
    rc0 = rlastCount;
    tick(0);
    reqQ0.push_back(mkAr(8'd0, 32'h3100));
    m0ArdySeen = 0;
    n = 0;
    while (rlastCount == rc0 && n < 40) begin
      tick(0);
      n++;
    end
    checkOutput("t3_timeout", n < 40, 1'b1);
    checkOutput("t3_m0_held_off", m0ArdySeen, 1'b0);
    checkOutput("t3_beats", m1Beats, 4);
    for (int k = 0; k < rx1.size() && k < 4; k++)
      checkOutput($sformatf("t3_beat_%0d", k), rx1[k], 64'hA5A5_0000_0000_0000 + 64'(k));
    rreadyMode = 0;
    tick(0);
    checkOutput("t3_m0_grant_after", m0Arready, 1'b1);
    runUntilIdle(30, "t3_drain");

    // Slave holds arready low: payload must stay put
    a = mkAr(8'd0, 32'h4000);
    reqQ0.push_back(a);
    arreadyStall = 6;
    tick(0);
    reqQ1.push_back(mkAr(8'd0, 32'h4100));
    for (int k = 0; k < 5; k++) begin
      tick(0);
      checkOutput("t4_s_arvalid", sArvalid, 1'b1);
      checkOutput("t4_s_ar", sAr, a);
      checkOutput("t4_arready", {m0Arready, m1Arready}, 2'b00);
    end
    runUntilIdle(40, "t4_drain");

    // Reset in the middle of a four-beat burst
    reqQ0.push_back(mkAr(8'd3, 32'h5000));
    for (int k = 0; k < 4; k++) tick(0);
    tick(1);
    tick(0);
    checkOutput("t5_outputs", {sArvalid, sRready, m0Rvalid, m1Rvalid, m0Arready, m1Arready}, 6'd0);
    checkOutput("t5_s_ar", sAr, 49'd0);
    rc0 = rlastCount;
    reqQ0.push_back(mkAr(8'd0, 32'h5100));
    runUntilIdle(30, "t5_fresh");
    checkOutput("t5_fresh_done", rlastCount, rc0 + 1);

    // Error response on the last beat to M1
    lastResp = 2'b10;
    m0RvSeen = 0;
    m1LastResp = 2'b00;
    rc0 = rlastCount;
    reqQ1.push_back(mkAr(8'd1, 32'h6000));
    n = 0;
    while (rlastCount == rc0 && n < 30) begin
      tick(0);
      n++;
    end
    checkOutput("t6_timeout", n < 30, 1'b1);
    checkOutput("t6_rresp", m1LastResp, 2'b10);
    checkOutput("t6_m0_rvalid_never", m0RvSeen, 1'b0);
    lastResp = 2'b00;
    reqQ0.push_back(mkAr(8'd0, 32'h6100));
    tick(0);
    checkOutput("t6_released", m0Arready, 1'b1);
    runUntilIdle(30, "t6_drain");

    // Randomized traffic, including stray slave rvalid outside the data phase
    randMode = 1;
    rreadyMode = 1;
    for (int k = 0; k < 30; k++) begin
      reqQ0.push_back(mkAr(8'($urandom_range(0, 3)), $urandom));
      reqQ1.push_back(mkAr(8'($urandom_range(0, 3)), $urandom));
    end
    runUntilIdle(5000, "rand_drain");
    randMode = 0;
    rreadyMode = 0;
    tick(0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
